// File: rtl/alu_issue_queue_if.sv
// Command/result bundle between an issue source, alu_issue_queue and its external ALU.
// The res_zero signal exists only when ALU_ISSUE_ZERO_FLAG_EN is defined.
interface alu_issue_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_a;
    logic [3:0]    in_b;
    logic          in_cin;
    logic [2:0]    in_ctrl;

    logic [3:0]    alu_a;
    logic [3:0]    alu_b;
    logic          alu_cin;
    logic [2:0]    alu_ctrl;
    logic [3:0]    alu_out;
    logic          alu_cout;

    logic          res_valid;
    logic          res_ready;
    logic [3:0]    res_data;
    logic          res_cout;
    logic [2:0]    res_ctrl;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    logic          res_zero;
`endif

    logic [CW-1:0] count;

    // master: the environment (command source, result sink and the ALU itself)
    modport master (
        output in_valid, in_a, in_b, in_cin, in_ctrl, res_ready, alu_out, alu_cout,
        input  in_ready, alu_a, alu_b, alu_cin, alu_ctrl,
        input  res_valid, res_data, res_cout, res_ctrl, count
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        , input res_zero
`endif
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_ctrl, res_ready, alu_out, alu_cout,
        output in_ready, alu_a, alu_b, alu_cin, alu_ctrl,
        output res_valid, res_data, res_cout, res_ctrl, count
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        , output res_zero
`endif
    );
endinterface

// File: rtl/alu_issue_queue.sv
// Command FIFO in front of a combinational ALU with a one-entry registered result stage.
// Optional zero flag on the result is enabled by defining ALU_ISSUE_ZERO_FLAG_EN.
module alu_issue_queue #(
    parameter int DEPTH = 4    // power of two, 2..16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_queue_if.slave q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [2:0] ctrl;
    } cmd_t;

    cmd_t          mem [DEPTH];
    cmd_t          head;
    cmd_t          in_cmd;

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          res_valid_reg;
    logic [3:0]    res_data_reg;
    logic          res_cout_reg;
    logic [2:0]    res_ctrl_reg;

    logic          not_empty;
    logic          in_ready;
    logic          push;
    logic          pop;

    assign not_empty = (count_reg != '0);
    assign in_ready  = (count_reg < CW'(DEPTH));
    assign push      = q.in_valid && in_ready;
    // The result stage frees up in the same cycle it is consumed downstream.
    assign pop       = not_empty && (!res_valid_reg || q.res_ready);

    assign in_cmd = '{a: q.in_a, b: q.in_b, cin: q.in_cin, ctrl: q.in_ctrl};
    assign head   = mem[rd_ptr_reg];

    assign q.in_ready = in_ready;
    assign q.alu_a    = not_empty ? head.a    : 4'b0;
    assign q.alu_b    = not_empty ? head.b    : 4'b0;
    assign q.alu_cin  = not_empty ? head.cin  : 1'b0;
    assign q.alu_ctrl = not_empty ? head.ctrl : 3'b0;

    assign q.res_valid = res_valid_reg;
    assign q.res_data  = res_data_reg;
    assign q.res_cout  = res_cout_reg;
    assign q.res_ctrl  = res_ctrl_reg;
    assign q.count     = count_reg;

    // Storage is never reset; occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_cmd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= 4'b0;
            res_cout_reg  <= 1'b0;
            res_ctrl_reg  <= 3'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (!push && pop) begin
                count_reg <= count_reg - CW'(1);
            end

            if (pop) begin
                res_valid_reg <= 1'b1;
                res_data_reg  <= q.alu_out;
                res_cout_reg  <= q.alu_cout;
                res_ctrl_reg  <= head.ctrl;
            end else if (q.res_ready) begin
                res_valid_reg <= 1'b0;
            end
        end
    end

`ifdef ALU_ISSUE_ZERO_FLAG_EN
    logic res_zero_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_zero_reg <= 1'b0;
        end else if (pop) begin
            res_zero_reg <= (q.alu_out == 4'b0000);
        end
    end

    assign q.res_zero = res_zero_reg;
`endif
endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue; models the external ALU and checks hand-computed results.
module tb_alu_issue_queue;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    alu_issue_queue_if #(.DEPTH(DEPTH)) ifc ();

    alu_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (ifc)
    );

    // External combinational ALU: sub reports borrow in the carry bit.
    always_comb begin
        ifc.alu_out  = 4'b0;
        ifc.alu_cout = 1'b0;
        case (ifc.alu_ctrl)
            3'b000: {ifc.alu_cout, ifc.alu_out} = {1'b0, ifc.alu_a} + {1'b0, ifc.alu_b} + {4'b0, ifc.alu_cin};
            3'b001: {ifc.alu_cout, ifc.alu_out} = {1'b0, ifc.alu_a} - {1'b0, ifc.alu_b} - {4'b0, ifc.alu_cin};
            3'b010: ifc.alu_out = ifc.alu_a & ifc.alu_b;
            3'b011: ifc.alu_out = ifc.alu_a | ifc.alu_b;
            3'b100: ifc.alu_out = ifc.alu_a ^ ifc.alu_b;
            3'b101: ifc.alu_out = ~ifc.alu_a;
            3'b110: {ifc.alu_cout, ifc.alu_out} = {ifc.alu_a, ifc.alu_cin};
            default: {ifc.alu_out, ifc.alu_cout} = {ifc.alu_cin, ifc.alu_a};
        endcase
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passes = passes + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic cin, input logic [2:0] ctrl);
        ifc.in_valid = v;
        ifc.in_a     = a;
        ifc.in_b     = b;
        ifc.in_cin   = cin;
        ifc.in_ctrl  = ctrl;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int pushed;
        int rcv;
        int cyc;

        drive(1'b0, 4'd0, 4'd0, 1'b0, 3'd0);
        ifc.res_ready = 1'b1;

        // Reset state before any clock edge
        #3;
        check("rst_count",     8'(ifc.count),     8'd0);
        check("rst_in_ready",  8'(ifc.in_ready),  8'd1);
        check("rst_res_valid", 8'(ifc.res_valid), 8'd0);
        check("rst_res_data",  8'(ifc.res_data),  8'd0);
        check("rst_alu_ctrl",  8'(ifc.alu_ctrl),  8'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 7 + 9 add: result appears one edge after the push
        drive(1'b1, 4'd7, 4'd9, 1'b0, 3'b000);
        tick();
        drive(1'b0, 4'd0, 4'd0, 1'b0, 3'd0);
        check("add_count_after_push", 8'(ifc.count), 8'd1);
        check("add_alu_a_head",       8'(ifc.alu_a), 8'd7);
        check("add_not_yet_valid",    8'(ifc.res_valid), 8'd0);
        tick();
        check("add_res_valid", 8'(ifc.res_valid), 8'd1);
        check("add_res_data",  8'(ifc.res_data),  8'h0);
        check("add_res_cout",  8'(ifc.res_cout),  8'd1);
        check("add_res_ctrl",  8'(ifc.res_ctrl),  8'd0);
        check("add_count",     8'(ifc.count),     8'd0);
        tick();
        check("add_valid_clears", 8'(ifc.res_valid), 8'd0);
        check("add_data_holds",   8'(ifc.res_data),  8'h0);

        // 3 - 5 sub: borrow
        drive(1'b1, 4'd3, 4'd5, 1'b0, 3'b001);
        tick();
        drive(1'b0, 4'd0, 4'd0, 1'b0, 3'd0);
        tick();
        check("sub_res_valid", 8'(ifc.res_valid), 8'd1);
        check("sub_res_data",  8'(ifc.res_data),  8'hE);
        check("sub_res_cout",  8'(ifc.res_cout),  8'd1);
        check("sub_res_ctrl",  8'(ifc.res_ctrl),  8'd1);
        tick();

        // Backpressure: six attempts, DEPTH+1 accepted, a=i b=1 gives i+1
        ifc.res_ready = 1'b0;
        acc = 0;
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 4'(i), 4'd1, 1'b0, 3'b000);
            if (ifc.in_ready) acc++;
            tick();
        end
        drive(1'b0, 4'd0, 4'd0, 1'b0, 3'd0);
        check("full_accepted",  8'(acc),           8'd5);
        check("full_count",     8'(ifc.count),     8'd4);
        check("full_in_ready",  8'(ifc.in_ready),  8'd0);
        check("full_res_valid", 8'(ifc.res_valid), 8'd1);
        check("full_res_data",  8'(ifc.res_data),  8'd2);
        tick();
        check("full_hold_data", 8'(ifc.res_data),  8'd2);
        check("full_hold_cnt",  8'(ifc.count),     8'd4);
        ifc.res_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            check("drain_valid", 8'(ifc.res_valid), 8'd1);
            check("drain_data",  8'(ifc.res_data),  8'(k + 1));
            tick();
        end
        check("drain_done_valid", 8'(ifc.res_valid), 8'd0);
        check("drain_done_count", 8'(ifc.count),     8'd0);
        check("drain_alu_a_zero", 8'(ifc.alu_a),     8'd0);

        // DEPTH+3 commands with res_ready toggling: pointers wrap, order kept
        pushed = 0;
        rcv    = 0;
        cyc    = 0;
        while ((rcv < 7) && (cyc < 60)) begin
            ifc.res_ready = ((cyc % 2) == 0);
            drive(pushed < 7, 4'(pushed), 4'd2, 1'b0, 3'b000);
            if (ifc.res_valid && ifc.res_ready) begin
                check("wrap_order", 8'(ifc.res_data), 8'(rcv + 2));
                rcv++;
            end
            if (ifc.in_valid && ifc.in_ready) pushed++;
            tick();
            cyc++;
        end
        drive(1'b0, 4'd0, 4'd0, 1'b0, 3'd0);
        ifc.res_ready = 1'b1;
        check("wrap_received", 8'(rcv), 8'd7);
        check("wrap_count",    8'(ifc.count), 8'd0);
        tick();

        // Asynchronous reset with queued and held commands: 9 - 2 = 7
        ifc.res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'd9, 4'd2, 1'b0, 3'b001);
            tick();
        end
        drive(1'b0, 4'd0, 4'd0, 1'b0, 3'd0);
        check("prerst_count",    8'(ifc.count),     8'd3);
        check("prerst_res_data", 8'(ifc.res_data),  8'd7);
        check("prerst_res_ctrl", 8'(ifc.res_ctrl),  8'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_count",     8'(ifc.count),     8'd0);
        check("arst_res_valid", 8'(ifc.res_valid), 8'd0);
        check("arst_res_data",  8'(ifc.res_data),  8'd0);
        check("arst_res_ctrl",  8'(ifc.res_ctrl),  8'd0);
        check("arst_in_ready",  8'(ifc.in_ready),  8'd1);
        check("arst_alu_a",     8'(ifc.alu_a),     8'd0);
        tick();
        rst_n = 1'b1;
        ifc.res_ready = 1'b1;
        tick();
        tick();
        check("postrst_res_valid", 8'(ifc.res_valid), 8'd0);
        check("postrst_count",     8'(ifc.count),     8'd0);

        // 5 - 5 gives zero with no borrow
        drive(1'b1, 4'd5, 4'd5, 1'b0, 3'b001);
        tick();
        drive(1'b0, 4'd0, 4'd0, 1'b0, 3'd0);
        tick();
        check("zero_res_valid", 8'(ifc.res_valid), 8'd1);
        check("zero_res_data",  8'(ifc.res_data),  8'd0);
        check("zero_res_cout",  8'(ifc.res_cout),  8'd0);
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        check("zero_flag_set",  8'(ifc.res_zero),  8'd1);
`endif
        drive(1'b1, 4'd2, 4'd1, 1'b0, 3'b000);
        tick();
        drive(1'b0, 4'd0, 4'd0, 1'b0, 3'd0);
        tick();
        check("nz_res_data", 8'(ifc.res_data), 8'd3);
        check("nz_res_ctrl", 8'(ifc.res_ctrl), 8'd0);
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        check("zero_flag_clr", 8'(ifc.res_zero), 8'd0);
`endif
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO entry count; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low; deassertion synchronous to clk.
REQ-004 in_valid  input  1  upstream command valid.
REQ-005 in_ready  output  1  queue can accept a command this cycle.
REQ-006 in_a, in_b  input  4 each  operands.
REQ-007 in_cin  input  1  carry/borrow in.
REQ-008 in_ctrl  input  3  ALU opcode, 000 add .. 111 rotate right.
REQ-009 alu_a, alu_b  output  4 each; alu_cin  output  1; alu_ctrl  output  3  head-entry fields driven to the combinational ALU.
REQ-010 alu_out  input  4; alu_cout  input  1  combinational ALU result for the alu_* drive.
REQ-011 res_valid  output  1; res_ready  input  1  downstream result handshake.
REQ-012 res_data  output  4; res_cout  output  1; res_ctrl  output  3  registered result, carry/borrow, opcode that produced it.
REQ-013 count  output  clog2(DEPTH)+1  FIFO occupancy, excluding the result register.

Function
REQ-014 Push SHALL occur on a rising edge when in_valid and in_ready are both high; in_ready SHALL equal (count < DEPTH), registered-state only, no combinational path from res_ready.
REQ-015 FIFO SHALL use wr/rd pointers of clog2(DEPTH) bits that wrap DEPTH-1 -> 0, plus a separate occupancy counter.
REQ-016 alu_* SHALL be driven combinationally from the head entry when count > 0, else all zeros.
REQ-017 Pop SHALL occur on an edge when count > 0 and (res_valid == 0 or res_ready == 1); on that edge res_data <= alu_out, res_cout <= alu_cout, res_ctrl <= head ctrl, res_valid <= 1.
REQ-018 If res_valid and res_ready are high and count == 0, res_valid SHALL clear on that edge; res_data/res_cout/res_ctrl hold.
REQ-019 res_* fields SHALL stay stable while res_valid is high and res_ready is low.
REQ-020 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-021 Latency: a command pushed into an empty queue on edge k SHALL appear with res_valid high after edge k+1; throughput one result per cycle when res_ready is held high.
REQ-022 Ordering SHALL be strictly FIFO; no command dropped or duplicated.
REQ-023 A push attempt while in_ready is low SHALL be ignored with no state change.

Reset
REQ-024 On rst_n low, immediately: count = 0, pointers = 0, res_valid = 0, res_data = 0, res_cout = 0, res_ctrl = 0; in_ready = 1 and alu_* = 0 follow.
REQ-025 Reset mid-operation SHALL discard all queued and held commands; FIFO storage need not be cleared.

Configuration
REQ-026 Macro ALU_ISSUE_ZERO_FLAG_EN: when defined, add output res_zero (1 bit), registered with res_data, high iff captured alu_out == 4'b0000, reset 0; when undefined, port and logic SHALL be absent and all other behaviour identical.

Verification
REQ-027 Empty queue, push a=7, b=9, cin=0, ctrl=000, res_ready=1 -> one cycle later res_valid=1, res_data=0, res_cout=1, res_ctrl=000.
REQ-028 Push a=3, b=5, cin=0, ctrl=001 -> res_data=E, res_cout=1 (borrow).
REQ-029 res_ready=0, push every cycle -> exactly DEPTH+1 (5) accepted, in_ready low, count=4, first result held stable; then res_ready=1 -> five results in push order on consecutive cycles.
REQ-030 Push DEPTH+3 commands with res_ready toggling 1/0 each cycle -> pointers wrap, all results in order, count returns to 0.
REQ-031 Assert rst_n low with count=3 and res_valid=1 -> res_valid, count, res_* zero without a clock edge; no stale result after release.
REQ-032 With ALU_ISSUE_ZERO_FLAG_EN, push a=5, b=5, cin=0, ctrl=001 -> res_data=0, res_zero=1, res_cout=0; without it, the same result is produced and no res_zero port exists.
